// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state and mode encodings for the 1:2 demux dispatcher
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD0 = 2'd1,
    ST_HOLD1 = 2'd2
  } state_t;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/demux_2_dispatcher_if.sv
// rtl/demux_2_dispatcher_if.sv - producer stream plus two consumer streams of the dispatcher
interface demux_2_dispatcher_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] Y0_data;
  logic             Y0_valid;
  logic             Y0_ready;
  logic [WIDTH-1:0] Y1_data;
  logic             Y1_valid;
  logic             Y1_ready;

  // Environment side: drives the producer and the consumer readys.
  modport master (
    output in_data, in_valid, in_sel, Y0_ready, Y1_ready,
    input  in_ready, Y0_data, Y0_valid, Y1_data, Y1_valid
  );

  // Dispatcher side.
  modport slave (
    input  in_data, in_valid, in_sel, Y0_ready, Y1_ready,
    output in_ready, Y0_data, Y0_valid, Y1_data, Y1_valid
  );
endinterface

// File: rtl/demux_2.sv
// rtl/demux_2.sv - combinational 1:2 demultiplexer, unselected output forced low
module demux_2 #(
  parameter int W = 1
) (
  input  logic [W-1:0] d_i,
  input  logic         sel_i,
  output logic [W-1:0] y0_o,
  output logic [W-1:0] y1_o
);

  assign y0_o = sel_i ? '0 : d_i;
  assign y1_o = sel_i ? d_i : '0;

endmodule

// File: rtl/demux_2_dispatcher.sv
// rtl/demux_2_dispatcher.sv - one-word-buffered 1:2 stream dispatcher (optional counters: DEMUX_DISPATCH_CNT_EN)
module demux_2_dispatcher
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  output logic busy,
  demux_2_dispatcher_if.slave bus
`ifdef DEMUX_DISPATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  state_t           state_q;
  logic [WIDTH-1:0] buf_q;
  logic             rr_ptr_q;

  logic y0_done;
  logic y1_done;
  logic accept;
  logic dest;
  logic v0;
  logic v1;

  // A held word leaves when its own consumer is ready; the other ready is ignored.
  assign y0_done = (state_q == ST_HOLD0) && bus.Y0_ready;
  assign y1_done = (state_q == ST_HOLD1) && bus.Y1_ready;

  assign bus.in_ready = (state_q == ST_IDLE) || y0_done || y1_done;
  assign accept       = bus.in_valid && bus.in_ready;
  assign dest         = (mode == MODE_RR) ? rr_ptr_q : bus.in_sel;
  assign busy         = (state_q != ST_IDLE);

  // Held-valid bit steered to the consumer chosen by the current hold state.
  demux_2 #(.W(1)) u_valid_demux (
    .d_i   (busy),
    .sel_i (state_q == ST_HOLD1),
    .y0_o  (v0),
    .y1_o  (v1)
  );

  assign bus.Y0_valid = v0;
  assign bus.Y1_valid = v1;
  assign bus.Y0_data  = (state_q == ST_HOLD0) ? buf_q : '0;
  assign bus.Y1_data  = (state_q == ST_HOLD1) ? buf_q : '0;

  // Dispatch FSM: capture on accept (back-to-back allowed), release to IDLE on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      rr_ptr_q <= 1'b0;
    end else if (accept) begin
      buf_q   <= bus.in_data;
      state_q <= dest ? ST_HOLD1 : ST_HOLD0;
      if (mode == MODE_RR) begin
        rr_ptr_q <= ~rr_ptr_q;
      end
    end else if (y0_done || y1_done) begin
      state_q <= ST_IDLE;
    end
  end

`ifdef DEMUX_DISPATCH_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Saturating counts of completed consumer handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (y0_done && (cnt0_q != '1)) begin
        cnt0_q <= cnt0_q + 1'b1;
      end
      if (y1_done && (cnt1_q != '1)) begin
        cnt1_q <= cnt1_q + 1'b1;
      end
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_demux_2_dispatcher.sv
// tb/tb_demux_2_dispatcher.sv - directed self-checking bench for demux_2_dispatcher
module tb_demux_2_dispatcher;

  logic clk;
  logic rst;
  logic mode;
  logic busy;
`ifdef DEMUX_DISPATCH_CNT_EN
  logic [3:0] cnt0;
  logic [3:0] cnt1;
`endif

  int n_assert;
  int n_fail;

  demux_2_dispatcher_if #(.WIDTH(8)) bus ();

`ifdef DEMUX_DISPATCH_CNT_EN
  demux_2_dispatcher #(.WIDTH(8), .CNT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .busy (busy),
    .bus  (bus),
    .cnt0 (cnt0),
    .cnt1 (cnt1)
  );
`else
  demux_2_dispatcher #(.WIDTH(8), .CNT_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .busy (busy),
    .bus  (bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    n_assert = 0;
    n_fail   = 0;

    rst          = 1'b1;
    mode         = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.Y0_ready = 1'b1;
    bus.Y1_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_busy",     busy,         0);
    chk("rst_y0_valid", bus.Y0_valid, 0);
    chk("rst_y1_valid", bus.Y1_valid, 0);
    chk("rst_y0_data",  bus.Y0_data,  0);
    chk("rst_in_ready", bus.in_ready, 1);

    // Async reset while holding A5 on Y0.
    bus.Y0_ready = 1'b0;
    bus.in_data  = 8'hA5;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("hold0_valid", bus.Y0_valid, 1);
    chk("hold0_data",  bus.Y0_data,  8'hA5);
    chk("hold0_busy",  busy,         1);
    chk("hold0_ready", bus.in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_y0_valid", bus.Y0_valid, 0);
    chk("async_y1_valid", bus.Y1_valid, 0);
    chk("async_busy",     busy,         0);
    chk("async_y0_data",  bus.Y0_data,  0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Explicit select, back-to-back.
    bus.Y0_ready = 1'b1;
    bus.Y1_ready = 1'b1;
    mode         = 1'b0;
    bus.in_data  = 8'h11;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    chk("sel_w1_y0_valid", bus.Y0_valid, 1);
    chk("sel_w1_y0_data",  bus.Y0_data,  8'h11);
    chk("sel_w1_y1_valid", bus.Y1_valid, 0);
    chk("sel_w1_y1_data",  bus.Y1_data,  0);
    chk("sel_w1_in_ready", bus.in_ready, 1);
    bus.in_data = 8'h22;
    bus.in_sel  = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("sel_w2_y1_valid", bus.Y1_valid, 1);
    chk("sel_w2_y1_data",  bus.Y1_data,  8'h22);
    chk("sel_w2_y0_valid", bus.Y0_valid, 0);
    chk("sel_w2_y0_data",  bus.Y0_data,  0);
    tick();
    chk("sel_idle_busy", busy, 0);

    // Round-robin ignores in_sel: odd words to Y0, even words to Y1.
    mode         = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      d           = 8'(i);
      bus.in_data = d;
      bus.in_sel  = 1'($urandom_range(0, 1));
      tick();
      if (i % 2 == 1) begin
        chk("rr_y0_valid", bus.Y0_valid, 1);
        chk("rr_y0_data",  bus.Y0_data,  d);
        chk("rr_y1_valid", bus.Y1_valid, 0);
      end else begin
        chk("rr_y1_valid", bus.Y1_valid, 1);
        chk("rr_y1_data",  bus.Y1_data,  d);
        chk("rr_y0_valid", bus.Y0_valid, 0);
      end
    end
    bus.in_valid = 1'b0;
    tick();
    chk("rr_idle_busy", busy, 0);

    // Backpressure on Y1; a pending word for Y0 must wait.
    mode         = 1'b0;
    bus.Y1_ready = 1'b0;
    bus.Y0_ready = 1'b1;
    bus.in_data  = 8'h5A;
    bus.in_sel   = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_data = 8'h77;
    bus.in_sel  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_y1_valid", bus.Y1_valid, 1);
      chk("bp_y1_data",  bus.Y1_data,  8'h5A);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_y0_valid", bus.Y0_valid, 0);
      if (k < 4) tick();
    end
    bus.Y1_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_next_y0_valid", bus.Y0_valid, 1);
    chk("bp_next_y0_data",  bus.Y0_data,  8'h77);
    chk("bp_next_y1_valid", bus.Y1_valid, 0);
    tick();
    chk("bp_idle_busy", busy, 0);

    // Mode switch while holding only affects the following word.
    mode         = 1'b1;
    bus.Y0_ready = 1'b0;
    bus.in_data  = 8'hC3;
    bus.in_sel   = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    mode         = 1'b0;
    bus.in_sel   = 1'b1;
    tick();
    chk("ms_hold_y0_valid", bus.Y0_valid, 1);
    chk("ms_hold_y0_data",  bus.Y0_data,  8'hC3);
    chk("ms_hold_y1_valid", bus.Y1_valid, 0);
    bus.Y0_ready = 1'b1;
    bus.in_data  = 8'h3C;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("ms_next_y1_valid", bus.Y1_valid, 1);
    chk("ms_next_y1_data",  bus.Y1_data,  8'h3C);
    chk("ms_next_y0_valid", bus.Y0_valid, 0);
    tick();
    chk("ms_idle_busy", busy, 0);

`ifdef DEMUX_DISPATCH_CNT_EN
    // Saturating delivery counters (CNT_W=4): 17 to Y0, 3 to Y1.
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("cnt0_reset", cnt0, 0);
    chk("cnt1_reset", cnt1, 0);
    mode         = 1'b0;
    bus.Y0_ready = 1'b1;
    bus.Y1_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    for (int i = 0; i < 17; i++) begin
      bus.in_data = 8'(i);
      tick();
    end
    bus.in_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(i + 8'h40);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("cnt0_saturated", cnt0, 4'hF);
    chk("cnt1_count",     cnt1, 4'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/demux_2_dispatcher.md
Name: demux_2_dispatcher

Overview:
Sequencing controller for the 1:2 demultiplexer datapath. It accepts words on one valid/ready input stream and delivers each word to exactly one of two consumers (Y0/Y1), using either an explicit per-word select or round-robin scheduling. It holds one buffered word and applies backpressure until the chosen consumer accepts it. It sits between a single producer and two downstream consumers sharing that producer.

Parameters:
WIDTH, 8, data word width in bits
CNT_W, 16, width of optional per-output delivery counters

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  input word
in_valid  input  1  producer has a word
in_ready  output  1  dispatcher accepts word this cycle
in_sel  input  1  destination for this word when mode=0 (0→Y0, 1→Y1)
mode  input  1  0 = explicit select, 1 = round-robin
Y0_data  output  WIDTH  word to consumer 0
Y0_valid  output  1  Y0_data valid
Y0_ready  input  1  consumer 0 accepts
Y1_data  output  WIDTH  word to consumer 1
Y1_valid  output  1  Y1_data valid
Y1_ready  input  1  consumer 1 accepts
busy  output  1  a word is held (state != IDLE)

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE, buffer=0, rr_ptr=0, Y0_valid=Y1_valid=0, Y0_data=Y1_data=0, busy=0, in_ready=1 once rst deasserts. A held word is discarded on reset mid-transfer.
- FSM states: IDLE, HOLD0, HOLD1.
- Destination dest = in_sel when mode=0, otherwise rr_ptr. The value is sampled only at the accept edge. A mode/in_sel change while holding affects only the next word.
- Accept condition: in_valid && in_ready.
  - On accept: buffer ← in_data; next state = HOLD<dest>.
  - If mode=1, rr_ptr toggles on each accept. rr_ptr does not change in mode 0.
- in_ready (combinational) = (state==IDLE) || (state==HOLD0 && Y0_ready) || (state==HOLD1 && Y1_ready).
- HOLDx: Yx_valid=1 and Yx_data=buffer. The other output has valid=0 and data=0, which keeps demux semantics with the unselected output forced low.
- HOLDx exit on Yx_ready:
  - If an accept happens in the same cycle, go to HOLD<new dest> with the new word (back-to-back, one word per cycle).
  - Otherwise go to IDLE.
- HOLDx with Yx_ready=0: hold state, buffer and outputs stable. The other consumer's ready is ignored.
- Latency: a word accepted at edge n appears on Yx at n (registered, visible in cycle n+1). Minimum one cycle from in_valid to Yx_valid.
- Yx_valid never deasserts before its handshake completes. Y0_valid and Y1_valid are never both 1.
- busy = (state != IDLE).

Optional Feature:
- Macro DEMUX_DISPATCH_CNT_EN.
- Defined: adds outputs cnt0 and cnt1 [CNT_W-1:0]. Each counts completed handshakes on Y0 and Y1 respectively. Both saturate at all-ones, reset to 0, and are cleared by rst only.
- Undefined: the ports and counter logic are absent. Core behaviour is identical in both cases.

Decomposition:
- Shared package demux_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_HOLD0=2'd1, ST_HOLD1=2'd2
  - mode constants MODE_SEL=1'b0, MODE_RR=1'b1
- Sub-module: instantiate the existing combinational demux_2 to steer the held-valid bit onto Y0_valid/Y1_valid via sel = (state==HOLD1).
- Data gating and FSM stay in the top module.

Test Plan:
1. Reset check: assert rst mid-HOLD0 with data 8'hA5 → Y0_valid=0, Y1_valid=0, busy=0 immediately (async). After release, in_ready=1.
2. Explicit select, mode=0: send 8'h11 (sel=0) then 8'h22 (sel=1) with both readys=1 → 8'h11 on Y0 at cycle 1, 8'h22 on Y1 at cycle 2, in_ready held 1, no idle cycle.
3. Round-robin, mode=1: stream 8'h01..8'h04 with in_sel toggling randomly → Y0 gets 01,03 and Y1 gets 02,04, regardless of in_sel.
4. Backpressure: mode=0, sel=1, data 8'h5A, Y1_ready=0 for 5 cycles, Y0_ready=1 → Y1_valid=1, Y1_data stable at 8'h5A, in_ready=0, Y0_valid=0. Word is delivered on the first cycle Y1_ready=1.
5. Mode switch while holding: word accepted in mode=1 (rr_ptr=0→Y0); flip mode=0, sel=1 during hold → held word still exits on Y0, and the next word goes to Y1.
6. With DEMUX_DISPATCH_CNT_EN and CNT_W=4: deliver 17 words to Y0 and 3 to Y1 → cnt0=4'hF (saturated), cnt1=4'h3.
